// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath sizes, opcode map, FSM state
// encoding and the opcode-to-flag-class helpers.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    function automatic logic sets_all_flags(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic sets_z_only(input logic [3:0] op);
        return (op == OP_XOR) || (op == OP_SLL) ||
               (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/flag_reg.sv
// Architectural Z/V/N flag register; each flag loads only when
// its own enable is set, otherwise it holds.
module flag_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic en_z_i,
    input  logic en_v_i,
    input  logic en_n_i,
    input  logic z_i,
    input  logic v_i,
    input  logic n_i,
    output logic z_o,
    output logic v_o,
    output logic n_o
);

    logic z_q, v_q, n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            if (en_z_i) z_q <= z_i;
            if (en_v_i) v_q <= v_i;
            if (en_n_i) n_q <= n_i;
        end
    end

    assign z_o = z_q;
    assign v_o = v_q;
    assign n_o = n_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with stall/flush handling, halt tracking
// and ownership of the architectural flag register.
import cpu_pkg::*;

module ex_mem_stage #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [3:0]        ex_opcode,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_ovfl,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wr_en,
    input  logic              stall,
    input  logic              flush,
    output logic              mem_valid,
    output logic [3:0]        mem_opcode,
    output logic [DATA_W-1:0] mem_result,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_wr_en,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n,
    output logic              halted
);

    state_e            state_q;
    logic              valid_q;
    logic [3:0]        opcode_q;
    logic [DATA_W-1:0] result_q;
    logic [REG_AW-1:0] rd_q;
    logic              wr_en_q;
    logic              halted_q;

    logic accept;
    logic upd_all;
    logic upd_z;

    assign accept = ex_valid & ~stall & ~flush & (state_q == ST_RUN);

    // Flush overrides stall: the register advances (as a bubble) when
    // either flush is high or the stage is not stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b0;
            opcode_q <= '0;
            result_q <= '0;
            rd_q     <= '0;
            wr_en_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            if (flush || !stall) begin
                valid_q <= accept;
                wr_en_q <= accept & ex_wr_en;
                if (accept) begin
                    opcode_q <= ex_opcode;
                    result_q <= ex_result;
                    rd_q     <= ex_rd;
                end
            end
            if (accept && (ex_opcode == OP_HLT)) begin
                state_q  <= ST_HALTED;
                halted_q <= 1'b1;
            end
        end
    end

    assign upd_all = accept & sets_all_flags(ex_opcode);
    assign upd_z   = accept & (sets_all_flags(ex_opcode) |
                               sets_z_only(ex_opcode));

    flag_reg u_flags (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_z_i (upd_z),
        .en_v_i (upd_all),
        .en_n_i (upd_all),
        .z_i    (ex_result == '0),
        .v_i    (ex_ovfl),
        .n_i    (ex_result[DATA_W-1]),
        .z_o    (flag_z),
        .v_o    (flag_v),
        .n_o    (flag_n)
    );

    assign mem_valid  = valid_q;
    assign mem_opcode = opcode_q;
    assign mem_result = result_q;
    assign mem_rd     = rd_q;
    assign mem_wr_en  = wr_en_q;
    assign halted     = halted_q;

endmodule
